// File: rtl/seq_detect_pkg.sv
// Shared types and width helpers for the serial pattern detector.
package seq_detect_pkg;

    typedef enum logic {
        FILL  = 1'b0,
        ARMED = 1'b1
    } fsm_state_t;

    function automatic int fill_cnt_w(input int len);
        return $clog2(len);
    endfunction

    // A period of 1 still needs a one-bit counter so the declaration stays legal.
    function automatic int strobe_cnt_w(input int period);
        return (period <= 1) ? 1 : $clog2(period);
    endfunction

endpackage

// File: rtl/seq_detect_shift_strobe_gen.sv
// Free-running sample strobe: pulses once every STROBE_PERIOD clk cycles.
module strobe_gen
    import seq_detect_pkg::*;
#(
    parameter int STROBE_PERIOD = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clr,
    output logic strobe
);

    localparam int CW = strobe_cnt_w(STROBE_PERIOD);
    localparam logic [CW-1:0] LAST = CW'(STROBE_PERIOD - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            cnt <= '0;
        end else if (clr || cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign strobe = (cnt == LAST);

endmodule

// File: rtl/seq_detect_shift.sv
// Strobe-paced serial pattern detector with overlap control and a saturating match counter.
module seq_detect_shift
    import seq_detect_pkg::*;
#(
    parameter int             LEN           = 4,
    parameter logic [LEN-1:0] PATTERN       = 4'b1011,
    parameter int             STROBE_PERIOD = 4,
    parameter int             CNT_W         = 8
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_bit,
    input  logic             en,
    input  logic             overlap,
    input  logic             clr,
    output logic [LEN-1:0]   shift_q,
    output logic             match,
    output logic [CNT_W-1:0] match_cnt,
    output logic             armed
);

    localparam int FW = fill_cnt_w(LEN);
    localparam logic [FW-1:0] FILL_LAST = FW'(LEN - 1);

    fsm_state_t     state;
    logic [FW-1:0]  fill_cnt;
    logic           strobe;
    logic           sample;
    logic [LEN-1:0] next_win;
    logic           window_full;
    logic           hit;

    strobe_gen #(
        .STROBE_PERIOD(STROBE_PERIOD)
    ) u_strobe (
        .clk    (clk),
        .reset_n(reset_n),
        .clr    (clr),
        .strobe (strobe)
    );

    assign sample   = strobe & en;
    assign next_win = {shift_q[LEN-2:0], in_bit};

    // The sample that completes the LEN-bit window is the first one compared;
    // earlier samples during FILL never match, whatever the stale bits hold.
    assign window_full = (state == ARMED) || (fill_cnt == FILL_LAST);
    assign hit         = sample && window_full && (next_win == PATTERN);

    always_ff @(posedge clk or posedge reset_n) begin
        if (reset_n) begin
            shift_q   <= '0;
            fill_cnt  <= '0;
            state     <= FILL;
            match     <= 1'b0;
            match_cnt <= '0;
        end else if (clr) begin
            shift_q   <= '0;
            fill_cnt  <= '0;
            state     <= FILL;
            match     <= 1'b0;
            match_cnt <= '0;
        end else begin
            match <= hit;
            if (hit && match_cnt != '1) begin
                match_cnt <= match_cnt + 1'b1;
            end
            if (sample) begin
                shift_q <= next_win;
                if (hit && !overlap) begin
                    // Non-overlapping: old bits stay in shift_q but must be refilled.
                    state    <= FILL;
                    fill_cnt <= '0;
                end else if (state == FILL) begin
                    if (fill_cnt == FILL_LAST) begin
                        state    <= ARMED;
                        fill_cnt <= '0;
                    end else begin
                        fill_cnt <= fill_cnt + 1'b1;
                    end
                end
            end
        end
    end

    assign armed = (state == ARMED);

endmodule

// File: tb/tb_seq_detect_shift.sv
// Directed bench for seq_detect_shift: default instance plus a fast, narrow-counter instance.
module tb_seq_detect_shift;

    logic       clk;
    logic       reset_n;

    logic       in_bit, en, overlap, clr;
    logic [3:0] shift_q;
    logic       match;
    logic [7:0] match_cnt;
    logic       armed;

    logic       s_in_bit, s_en, s_overlap, s_clr;
    logic [3:0] s_shift_q;
    logic       s_match;
    logic [1:0] s_match_cnt;
    logic       s_armed;

    int tests_run;
    int tests_failed;

    seq_detect_shift dut (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_bit   (in_bit),
        .en       (en),
        .overlap  (overlap),
        .clr      (clr),
        .shift_q  (shift_q),
        .match    (match),
        .match_cnt(match_cnt),
        .armed    (armed)
    );

    seq_detect_shift #(
        .LEN          (4),
        .PATTERN      (4'b1011),
        .STROBE_PERIOD(1),
        .CNT_W        (2)
    ) dut_sat (
        .clk      (clk),
        .reset_n  (reset_n),
        .in_bit   (s_in_bit),
        .en       (s_en),
        .overlap  (s_overlap),
        .clr      (s_clr),
        .shift_q  (s_shift_q),
        .match    (s_match),
        .match_cnt(s_match_cnt),
        .armed    (s_armed)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running expected done");
        $fatal(1);
    end

    task automatic do_reset();
        reset_n = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b0;
    endtask

    // One sample of the default instance: strobe lands on the 4th edge.
    task automatic sample_bit(input logic b);
        in_bit = b;
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        in_bit = 1'b0; en = 1'b0; overlap = 1'b1; clr = 1'b0;
        s_in_bit = 1'b0; s_en = 1'b0; s_overlap = 1'b1; s_clr = 1'b0;
        reset_n = 1'b1;
        @(negedge clk);
        tests_run++;
        if (shift_q !== 4'b0000) begin
            tests_failed++;
            $display("FAIL reset_shift: got %b expected 0000", shift_q);
        end
        tests_run++;
        if (match !== 1'b0 || armed !== 1'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: got match=%b armed=%b expected 0 0", match, armed);
        end
        tests_run++;
        if (match_cnt !== 8'd0 || s_match_cnt !== 2'd0) begin
            tests_failed++;
            $display("FAIL reset_cnt: got %0d/%0d expected 0/0", match_cnt, s_match_cnt);
        end
        reset_n = 1'b0;
    endtask

    task automatic test_overlap();
        logic [6:0] stream  = 7'b1011011;
        logic [6:0] exp_m   = 7'b0001001;
        logic [7:0] exp_cnt;
        do_reset();
        overlap = 1'b1; en = 1'b1;
        exp_cnt = 8'd0;
        for (int i = 0; i < 7; i++) begin
            sample_bit(stream[6-i]);
            if (exp_m[6-i]) exp_cnt = exp_cnt + 8'd1;
            tests_run++;
            if (match !== exp_m[6-i] || match_cnt !== exp_cnt) begin
                tests_failed++;
                $display("FAIL overlap_s%0d: got match=%b cnt=%0d expected match=%b cnt=%0d",
                         i + 1, match, match_cnt, exp_m[6-i], exp_cnt);
            end
        end
        tests_run++;
        if (shift_q !== 4'b1011 || armed !== 1'b1) begin
            tests_failed++;
            $display("FAIL overlap_end: got shift=%b armed=%b expected 1011 1", shift_q, armed);
        end
    endtask

    task automatic test_nonoverlap();
        logic [6:0] stream = 7'b1011011;
        logic [6:0] exp_m  = 7'b0001000;
        do_reset();
        overlap = 1'b0; en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            sample_bit(stream[6-i]);
            tests_run++;
            if (match !== exp_m[6-i]) begin
                tests_failed++;
                $display("FAIL nonoverlap_s%0d: got match=%b expected %b", i + 1, match, exp_m[6-i]);
            end
        end
        tests_run++;
        if (match_cnt !== 8'd1 || armed !== 1'b0) begin
            tests_failed++;
            $display("FAIL nonoverlap_end: got cnt=%0d armed=%b expected 1 0", match_cnt, armed);
        end
    endtask

    task automatic test_strobe();
        logic [4:0] stream = 5'b10110;
        logic [3:0] exp_shift;
        do_reset();
        overlap = 1'b1; en = 1'b1;
        exp_shift = 4'b0000;
        for (int i = 0; i < 5; i++) begin
            for (int k = 0; k < 3; k++) begin
                in_bit = (k % 2 == 0) ? ~stream[4-i] : stream[4-i];
                @(posedge clk);
                #1;
                tests_run++;
                if (shift_q !== exp_shift || match !== 1'b0) begin
                    tests_failed++;
                    $display("FAIL strobe_gap_s%0d_c%0d: got shift=%b match=%b expected %b 0",
                             i + 1, k, shift_q, match, exp_shift);
                end
            end
            in_bit = stream[4-i];
            @(posedge clk);
            #1;
            exp_shift = {exp_shift[2:0], stream[4-i]};
            tests_run++;
            if (shift_q !== exp_shift || match !== (i == 3)) begin
                tests_failed++;
                $display("FAIL strobe_edge_s%0d: got shift=%b match=%b expected %b %b",
                         i + 1, shift_q, match, exp_shift, (i == 3));
            end
        end
    endtask

    task automatic test_en_hold();
        do_reset();
        overlap = 1'b1; en = 1'b1;
        sample_bit(1'b1);
        sample_bit(1'b0);
        en = 1'b0;
        for (int c = 0; c < 20; c++) begin
            in_bit = ~in_bit;
            @(posedge clk);
            #1;
            tests_run++;
            if (shift_q !== 4'b0010 || armed !== 1'b0 || match !== 1'b0) begin
                tests_failed++;
                $display("FAIL en_hold_c%0d: got shift=%b armed=%b match=%b expected 0010 0 0",
                         c, shift_q, armed, match);
            end
        end
        en = 1'b1;
        sample_bit(1'b1);
        tests_run++;
        if (shift_q !== 4'b0101 || armed !== 1'b0) begin
            tests_failed++;
            $display("FAIL en_resume3: got shift=%b armed=%b expected 0101 0", shift_q, armed);
        end
        sample_bit(1'b1);
        tests_run++;
        if (shift_q !== 4'b1011 || armed !== 1'b1 || match !== 1'b1) begin
            tests_failed++;
            $display("FAIL en_resume4: got shift=%b armed=%b match=%b expected 1011 1 1",
                     shift_q, armed, match);
        end
    endtask

    task automatic test_saturate();
        logic [3:0] pat = 4'b1011;
        logic [1:0] exp_cnt;
        do_reset();
        s_en = 1'b1; s_overlap = 1'b1;
        exp_cnt = 2'd0;
        for (int r = 0; r < 5; r++) begin
            for (int j = 0; j < 4; j++) begin
                s_in_bit = pat[3-j];
                @(posedge clk);
                #1;
                if (j == 3 && exp_cnt != 2'd3) exp_cnt = exp_cnt + 2'd1;
                tests_run++;
                if (s_match !== (j == 3) || s_match_cnt !== exp_cnt) begin
                    tests_failed++;
                    $display("FAIL sat_r%0d_b%0d: got match=%b cnt=%0d expected %b %0d",
                             r, j, s_match, s_match_cnt, (j == 3), exp_cnt);
                end
            end
        end
        s_en = 1'b0;
    endtask

    task automatic test_edge_cases();
        do_reset();
        overlap = 1'b1; en = 1'b1;
        sample_bit(1'b1);
        sample_bit(1'b0);
        sample_bit(1'b1);
        in_bit = 1'b1;
        repeat (3) @(posedge clk);
        clr = 1'b1;
        @(posedge clk);
        #1;
        clr = 1'b0;
        tests_run++;
        if (match !== 1'b0 || shift_q !== 4'b0000 || match_cnt !== 8'd0 || armed !== 1'b0) begin
            tests_failed++;
            $display("FAIL clr_on_sample: got match=%b shift=%b cnt=%0d armed=%b expected 0 0000 0 0",
                     match, shift_q, match_cnt, armed);
        end
        sample_bit(1'b1);
        sample_bit(1'b0);
        sample_bit(1'b1);
        sample_bit(1'b1);
        tests_run++;
        if (match !== 1'b1 || match_cnt !== 8'd1 || armed !== 1'b1) begin
            tests_failed++;
            $display("FAIL after_clr: got match=%b cnt=%0d armed=%b expected 1 1 1",
                     match, match_cnt, armed);
        end
        #2;
        reset_n = 1'b1;
        #1;
        tests_run++;
        if (shift_q !== 4'b0000 || match !== 1'b0 || match_cnt !== 8'd0 || armed !== 1'b0) begin
            tests_failed++;
            $display("FAIL async_reset: got shift=%b match=%b cnt=%0d armed=%b expected 0000 0 0 0",
                     shift_q, match, match_cnt, armed);
        end
        @(negedge clk);
        reset_n = 1'b0;
        sample_bit(1'b0);
        sample_bit(1'b0);
        sample_bit(1'b0);
        tests_run++;
        if (armed !== 1'b0) begin
            tests_failed++;
            $display("FAIL refill3: got armed=%b expected 0", armed);
        end
        sample_bit(1'b0);
        tests_run++;
        if (armed !== 1'b1 || match !== 1'b0) begin
            tests_failed++;
            $display("FAIL refill4: got armed=%b match=%b expected 1 0", armed, match);
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        test_reset();
        test_overlap();
        test_nonoverlap();
        test_strobe();
        test_en_hold();
        test_saturate();
        test_edge_cases();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/seq_detect_shift.md
# seq_detect_shift

Parametrised serial pattern detector: a free-running strobe generator paces sampling of a 1-bit input into a LEN-bit shift register, and a small FSM tracks window fill and reports matches against a compile-time PATTERN. It supports overlapping and non-overlapping detection and keeps a saturating match counter. It replaces the fixed-width shift-register and FSM pair in the board-level lab top, fed from a key/switch input and driving LEDs or a display.

## Interface
- LEN, 4: shift register and pattern length; must be ≥ 2.
- PATTERN, 4'b1011: LEN-bit pattern. The MSB is the oldest sample.
- STROBE_PERIOD, 4: clk cycles per sample strobe; must be ≥ 1. A value of 1 strobes every cycle.
- CNT_W, 8: match counter width.
- clk  in  1  clock; all state updates on the rising edge.
- reset_n  in  1  reset; asynchronous, active-high.
- in_bit  in  1  serial data input.
- en  in  1  sample enable; a sample is taken only when strobe and en are both high.
- overlap  in  1  detection mode: 1 = overlapping, 0 = non-overlapping. Sampled on every sample.
- clr  in  1  synchronous clear of shift register, FSM, strobe counter and match counter.
- shift_q  out  LEN  shift register contents.
- match  out  1  one-cycle match pulse.
- match_cnt  out  CNT_W  saturating count of matches.
- armed  out  1  high while the FSM is in ARMED.

## Operation
- Strobe generator: counter runs 0..STROBE_PERIOD-1, wraps, and runs regardless of en. strobe = (counter == STROBE_PERIOD-1).
- sample = strobe & en.
- On sample, shift_q ← {shift_q[LEN-2:0], in_bit}. The new bit enters at the LSB.
- fill_cnt (0..LEN-1) counts valid bits while in FILL.
- FSM states are FILL and ARMED.
  - FILL, on sample: if fill_cnt == LEN-1, go to ARMED and clear fill_cnt; otherwise fill_cnt+1. No match is evaluated in FILL, even if the window equals PATTERN.
  - ARMED, on sample: compare the next window {shift_q[LEN-2:0], in_bit} with PATTERN.
  - On equal: match ← 1, match_cnt+1 unless all-ones, which saturates.
  - After a match with overlap=0: go to FILL with fill_cnt=0. Old bits stay in shift_q but are not counted.
  - After a match with overlap=1: stay in ARMED.
- match is 0 in every cycle not immediately following a matching sample.
- clr has priority over sample in the same cycle. It zeroes shift_q, fill_cnt, the strobe counter and match_cnt, and sets state to FILL and match to 0.
- en low freezes shift_q, fill_cnt and state; the strobe counter keeps running.

## Timing
- Reset, and clr one edge later: shift_q=0, match=0, match_cnt=0, armed=0, state=FILL, strobe counter=0.
- Reset may assert at any time, including mid-fill or mid-match. All outputs go to reset values immediately. After release, detection restarts from an empty window.
- First sample after reset is at the edge that ends cycle STROBE_PERIOD-1.
- Match latency: match is high for exactly the one clk cycle after the sampling edge. In that cycle shift_q == PATTERN and match_cnt already shows the incremented value.
- armed rises in the cycle after the LEN-th counted sample.
- Minimum spacing between match pulses:
  - overlap=1: one sample.
  - overlap=0: LEN samples.
- Counter wrap: match_cnt holds at 2^CNT_W-1 and match still pulses.

## Structure
- Package seq_detect_pkg holds:
  - the state enum typedef (FILL, ARMED);
  - the width helper for fill_cnt, $clog2(LEN);
  - the width helper for the strobe counter, $clog2(STROBE_PERIOD), with a minimum of 1.
- Sub-module strobe_gen, parametrised by STROBE_PERIOD, with ports clk, reset_n, clr and strobe.
- The top holds the shift register, the FSM and the counter.

## Test plan
- Defaults, en=1, overlap=1, input stream 1,0,1,1,0,1,1: match pulses after the 4th sample (stream 1011) and after the 7th (stream 1011, overlapping window). match_cnt=2.
- Same stream with overlap=0: one match after the 4th sample only. The 7th-sample window is not counted because only 3 bits have been refilled. match_cnt=1.
- STROBE_PERIOD=4, en=1: sampling edges occur every 4 clk. Changing in_bit between strobes has no effect on shift_q.
- en held 0 for 20 cycles mid-fill, then released: shift_q and armed are unchanged during the hold, and fill resumes from the saved fill_cnt.
- CNT_W=2, STROBE_PERIOD=1, overlap=1, repeated 1011 stream: match_cnt saturates at 3 while match keeps pulsing.
- Edge cases in one sequence:
  - clr asserted on a sampling cycle: clear wins and match stays 0.
  - reset_n pulsed asynchronously mid-cycle while armed: outputs clear without waiting for a clk edge.
